// File: rtl/rf_bank_pkg.sv
// rf_bank_pkg: shared defaults for the rf_bank register file.
//   DEF_DATA_W    default data width in bits (multiple of 8)
//   DEF_DEPTH     default number of registers
//   DEF_ADDR_W    default address width
//   DEF_BASE_ADDR default address of register 0
//   strb_w()      byte-strobe width for a given data width
package rf_bank_pkg;

  localparam int DEF_DATA_W    = 64;
  localparam int DEF_DEPTH     = 23;
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_BASE_ADDR = 0;

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/rf_bank_dec.sv
// rf_bank_dec: combinational address decode for rf_bank.
// Ports:
//   addr   in  ADDR_W  shared read/write address
//   we     in  1       write request
//   hit    out 1       address falls inside the register window
//   index  out IDX_W   register index (meaningful only when hit=1)
//   wr_en  out DEPTH   one-hot per-register write enable, gated by we and hit
module rf_bank_dec
  import rf_bank_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int BASE_ADDR = DEF_BASE_ADDR,
  parameter int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  output logic              hit,
  output logic [IDX_W-1:0]  index,
  output logic [DEPTH-1:0]  wr_en
);

  // Compare in a 33-bit space so BASE_ADDR+DEPTH can never wrap.
  logic [32:0] addr_ext;
  logic [32:0] offset;

  assign addr_ext = 33'(addr);
  assign offset   = addr_ext - 33'(BASE_ADDR);
  assign hit      = (addr_ext >= 33'(BASE_ADDR)) &&
                    (addr_ext <  33'(BASE_ADDR) + 33'(DEPTH));
  assign index    = offset[IDX_W-1:0];

  always_comb begin
    wr_en = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_en[i] = we && hit && (offset == 33'(i));
    end
  end

endmodule

// File: rtl/rf_bank.sv
// rf_bank: byte-strobed register file with a registered read port.
// Optional feature: define RF_BANK_BYPASS_EN to make a same-cycle read and
// write to one address return the post-write value; otherwise the pre-write
// value is returned.
// Ports:
//   clk      in  1         clock, rising edge
//   reset_n  in  1         asynchronous active-low reset
//   Addr     in  ADDR_W    shared read/write address
//   we       in  1         write request
//   wStrb    in  DATA_W/8  byte write enables
//   wData    in  DATA_W    write data
//   re       in  1         read request
//   rData    out DATA_W    registered read data (held between reads)
//   rValid   out 1         one-cycle pulse per read
//   err      out 1         one-cycle pulse on an out-of-range access
module rf_bank
  import rf_bank_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [ADDR_W-1:0]          Addr,
  input  logic                       we,
  input  logic [strb_w(DATA_W)-1:0]  wStrb,
  input  logic [DATA_W-1:0]          wData,
  input  logic                       re,
  output logic [DATA_W-1:0]          rData,
  output logic                       rValid,
  output logic                       err
);

  localparam int STRB_W = strb_w(DATA_W);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              hit;
  logic [IDX_W-1:0]  index;
  logic [DEPTH-1:0]  wr_en;
  logic [DATA_W-1:0] old_val;
  logic [DATA_W-1:0] new_val;
  logic [DATA_W-1:0] rd_val;
  logic              access;

  rf_bank_dec #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .IDX_W     (IDX_W)
  ) u_dec (
    .addr  (Addr),
    .we    (we),
    .hit   (hit),
    .index (index),
    .wr_en (wr_en)
  );

  // Read mux built as a loop so a miss never indexes past the array.
  always_comb begin
    old_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (hit && (index == IDX_W'(i))) old_val = regs[i];
    end
  end

  // Value the addressed register will hold after this edge's write.
  always_comb begin
    new_val = old_val;
    if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wStrb[b]) new_val[b*8 +: 8] = wData[b*8 +: 8];
      end
    end
  end

`ifdef RF_BANK_BYPASS_EN
  assign rd_val = new_val;
`else
  assign rd_val = old_val;
`endif

  // A write with no strobes is a no-op, so it does not count as an access.
  assign access = re || (we && (|wStrb));

  // Register array: byte-granular writes to the one-hot selected register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wStrb[b]) regs[i][b*8 +: 8] <= wData[b*8 +: 8];
          end
        end
      end
    end
  end

  // Read pipeline: one-cycle latency; misses return zero and flag err.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rData  <= '0;
      rValid <= 1'b0;
      err    <= 1'b0;
    end else begin
      rValid <= re;
      err    <= access && !hit;
      if (re) rData <= hit ? rd_val : '0;
    end
  end

endmodule

// File: doc/rf_bank.md
RF_BANK -- requirements
Module: rf_bank

Interface
REQ-001 Parameter: DATA_W, default 64, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter: DEPTH, default 23, number of registers.
REQ-003 Parameter: ADDR_W, default 16, address width.
REQ-004 Parameter: BASE_ADDR, default 0, address of register 0.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 reset_n  input  1  reset, asynchronous and active-low.
REQ-007 Addr  input  ADDR_W  shared read/write address.
REQ-008 we  input  1  write request.
REQ-009 wStrb  input  DATA_W/8  byte write enables.
REQ-010 wData  input  DATA_W  write data.
REQ-011 re  input  1  read request.
REQ-012 rData  output  DATA_W  registered read data.
REQ-013 rValid  output  1  one-cycle pulse marking new rData.
REQ-014 err  output  1  one-cycle pulse on an out-of-range access.

Function
REQ-015 Hit: Addr SHALL hit when BASE_ADDR <= Addr < BASE_ADDR+DEPTH; index = Addr-BASE_ADDR.
REQ-016 Write: on an edge with we=1 and a hit, each byte i of register[index] with wStrb[i]=1 SHALL take wData byte i; all other bytes and registers SHALL hold.
REQ-017 A write with wStrb all zero SHALL change nothing and SHALL NOT raise err.
REQ-018 Read latency: re=1 sampled at edge N SHALL produce rData and rValid=1 after edge N, visible in cycle N+1.
REQ-019 rValid SHALL be 1 for exactly one cycle per accepted read; back-to-back reads SHALL give back-to-back pulses.
REQ-020 rData SHALL hold its last value when no read occurs.
REQ-021 Out-of-range read: rData SHALL be 0, rValid SHALL be 1, err SHALL be 1 in the same cycle.
REQ-022 Out-of-range write with a nonzero wStrb: no register SHALL change, and err SHALL pulse for one cycle.
REQ-023 Simultaneous we and re at the same hit address: the write SHALL be performed; rData SHALL follow REQ-030 and REQ-031.
REQ-024 err SHALL be 1 after edge N when any out-of-range access with we or re occurred at edge N; otherwise it SHALL be 0.

Reset
REQ-025 While reset_n=0, all DEPTH registers SHALL be 0, immediately and independent of clk.
REQ-026 While reset_n=0, rData SHALL be 0, rValid SHALL be 0 and err SHALL be 0.
REQ-027 An access pending when reset asserts SHALL be discarded.
REQ-028 After reset releases, the first edge SHALL accept accesses normally.

Configuration
REQ-029 Macro RF_BANK_BYPASS_EN SHALL select read-during-write behaviour.
REQ-030 With RF_BANK_BYPASS_EN defined: for a same-cycle read and write to the same address, rData SHALL return the post-write value (strobed bytes from wData, others from the old value).
REQ-031 Without RF_BANK_BYPASS_EN: for the same case, rData SHALL return the pre-write value.

Structure
REQ-032 Package rf_bank_pkg SHALL hold the default DATA_W, DEPTH, ADDR_W and BASE_ADDR constants and the strobe-width function DATA_W/8.
REQ-033 Sub-module rf_bank_dec SHALL perform the combinational address decode, outputting a one-hot DEPTH-bit write enable gated by we and a hit flag.
REQ-034 The register array and read pipeline SHALL reside in rf_bank.

Verification
REQ-035 Reset: drive reset_n=0 mid-cycle, then read all 23 addresses -> each read returns 0 with rValid=1 and err=0.
REQ-036 Strobes: write 0xFFFF_FFFF_FFFF_FFFF to addr 5 with wStrb=0xFF, then 0x0 with wStrb=0x0F, then read addr 5 -> rData=0xFFFF_FFFF_0000_0000.
REQ-037 Range: write to addr 23 with wStrb=0xFF, then read addr 23 -> err pulses once for each access, rData=0, and registers 0..22 are unchanged.
REQ-038 Read-during-write: we=re=1 at addr 3, old=0x11, new=0x22 -> rData=0x22 with the macro defined, 0x11 without.
REQ-039 Streaming: read addrs 0,1,2 on consecutive edges -> rValid high for 3 consecutive cycles with matching data in order.
REQ-040 Base offset: with BASE_ADDR=0x100, write to Addr 0x100 hits index 0, and access to Addr 0x0FF raises err.
